// File: rtl/alu_fsm_core.sv
// Multi-cycle ALU with IDLE/LOAD/EXEC/DONE controller.
// MUL is a WIDTH-cycle shift-add; other ops finish in one EXEC cycle.
module alu_fsm_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             on,
   input  logic [2:0]       in_sel,
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   input  logic [6:0]       out_sel,
   output logic [WIDTH-1:0] final1,
   output logic [WIDTH-1:0] final2,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             ovf,
   output logic             zero,
   output logic             err,
   output logic             busy,
   output logic             done,
   output logic [1:0]       curr_state,
   output logic [1:0]       next_state
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      EXEC = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [6:0] OP_MUL = 7'b0010000;

   state_t state_q;
   state_t state_d;

   logic [6:0]         op_q;
   logic [6:0]         op_v;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [CW-1:0]      cnt_q;

   logic             cmd_load;
   logic             cmd_pers;
   logic             cmd_clr;
   logic             op_ok;
   logic             is_mul;
   logic             mul_last;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   dif;
   logic [WIDTH-1:0] res;
   logic             res_c;
   logic             res_v;

   assign cmd_load = (in_sel == 3'b010);
   assign cmd_pers = (in_sel == 3'b100);
   assign cmd_clr  = (in_sel == 3'b001);

   assign op_ok    = (op_q != '0) && ((op_q & (op_q - 7'd1)) == '0);
   assign op_v     = op_ok ? op_q : '0;
   assign is_mul   = (op_q == OP_MUL);
   assign mul_last = (cnt_q == LAST);

   // one partial product per cycle, selected by the current counter bit
   assign acc_d = acc_q + (final2[cnt_q]
                  ? ({{WIDTH{1'b0}}, final1} << cnt_q)
                  : '0);

   assign curr_state = state_q;
   assign next_state = state_d;
   assign busy = (state_q == LOAD) || (state_q == EXEC);
   assign done = (state_q == DONE);

   always_comb begin
      sum   = {1'b0, final1} + {1'b0, final2};
      dif   = {1'b0, final1} - {1'b0, final2};
      res   = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      unique case (1'b1)
         op_v[6]: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (final1[WIDTH-1] == final2[WIDTH-1])
                 && (sum[WIDTH-1] != final1[WIDTH-1]);
         end
         op_v[5]: begin
            res   = dif[WIDTH-1:0];
            res_c = dif[WIDTH];
            res_v = (final1[WIDTH-1] != final2[WIDTH-1])
                 && (dif[WIDTH-1] != final1[WIDTH-1]);
         end
         op_v[4]: begin
            res   = acc_d[WIDTH-1:0];
            res_c = |acc_d[2*WIDTH-1:WIDTH];
         end
         op_v[3]: res = final1 & final2;
         op_v[2]: res = final1 | final2;
         op_v[1]: res = final1 ^ final2;
         op_v[0]: res = ~final1;
         default: res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      if (!on) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (cmd_load || cmd_pers) state_d = LOAD;
            LOAD: state_d = EXEC;
            EXEC: if (!is_mul || mul_last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         final1  <= '0;
         final2  <= '0;
         out     <= '0;
         carry   <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b0;
         err     <= 1'b0;
         op_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (on) begin
            case (state_q)
               IDLE: begin
                  if (cmd_load) begin
                     final1 <= num1;
                     final2 <= num2;
                     op_q   <= out_sel;
                  end else if (cmd_pers) begin
                     op_q <= out_sel;
                  end else if (cmd_clr) begin
                     final1 <= '0;
                     final2 <= '0;
                     out    <= '0;
                     carry  <= 1'b0;
                     ovf    <= 1'b0;
                     zero   <= 1'b0;
                     err    <= 1'b0;
                  end
               end
               LOAD: begin
                  acc_q <= '0;
                  cnt_q <= '0;
               end
               EXEC: begin
                  if (is_mul) begin
                     acc_q <= acc_d;
                     cnt_q <= cnt_q + CW'(1);
                  end
                  if (!is_mul || mul_last) begin
                     out   <= res;
                     carry <= res_c;
                     ovf   <= res_v;
                     zero  <= (res == '0);
                     err   <= !op_ok;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_fsm_core.sv
// Directed bench for alu_fsm_core (WIDTH=8).
// Table of single ops plus hand-written reset/enable/busy sequences.
module tb_alu_fsm_core;

   localparam int W = 8;

   localparam logic [2:0] LD = 3'b010;
   localparam logic [2:0] PS = 3'b100;
   localparam logic [2:0] CL = 3'b001;

   localparam logic [6:0] ADD = 7'b1000000;
   localparam logic [6:0] SUB = 7'b0100000;
   localparam logic [6:0] MUL = 7'b0010000;
   localparam logic [6:0] AND = 7'b0001000;
   localparam logic [6:0] OR  = 7'b0000100;
   localparam logic [6:0] XOR = 7'b0000010;
   localparam logic [6:0] NOT = 7'b0000001;

   typedef struct {
      logic [2:0]   cmd;
      logic [W-1:0] n1;
      logic [W-1:0] n2;
      logic [6:0]   sel;
      logic [W-1:0] e_out;
      logic [3:0]   e_flg;
      int           e_lat;
      logic [W-1:0] e_f1;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         on;
   logic [2:0]   in_sel;
   logic [W-1:0] num1;
   logic [W-1:0] num2;
   logic [6:0]   out_sel;
   logic [W-1:0] final1;
   logic [W-1:0] final2;
   logic [W-1:0] out;
   logic         carry;
   logic         ovf;
   logic         zero;
   logic         err;
   logic         busy;
   logic         done;
   logic [1:0]   curr_state;
   logic [1:0]   next_state;

   int n_pass = 0;
   int n_tot  = 0;

   alu_fsm_core #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .on         (on),
      .in_sel     (in_sel),
      .num1       (num1),
      .num2       (num2),
      .out_sel    (out_sel),
      .final1     (final1),
      .final2     (final2),
      .out        (out),
      .carry      (carry),
      .ovf        (ovf),
      .zero       (zero),
      .err        (err),
      .busy       (busy),
      .done       (done),
      .curr_state (curr_state),
      .next_state (next_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   function automatic logic [3:0] flags();
      return {carry, ovf, zero, err};
   endfunction

   task automatic run(input string nm, input vec_t v);
      int lat;
      int nb;
      @(negedge clk);
      in_sel  = v.cmd;
      num1    = v.n1;
      num2    = v.n2;
      out_sel = v.sel;
      @(posedge clk);
      #1;
      in_sel = 3'b000;
      lat = 0;
      nb  = 0;
      while (!done && lat < 40) begin
         nb += int'(busy);
         @(posedge clk);
         #1;
         lat++;
      end
      chk({nm, "_out"}, 32'(out), 32'(v.e_out));
      chk({nm, "_flg"}, 32'(flags()), 32'(v.e_flg));
      chk({nm, "_lat"}, lat, v.e_lat);
      chk({nm, "_busy"}, nb, v.e_lat);
      chk({nm, "_f1"}, 32'(final1), 32'(v.e_f1));
      @(posedge clk);
      #1;
      chk({nm, "_idle"}, {done, curr_state}, 3'b000);
   endtask

   task automatic watch_no_done(input string nm, input int n);
      int seen;
      seen = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         seen += int'(done);
      end
      chk(nm, seen, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      vec_t tv[15];
      vec_t v;

      tv[0]  = '{LD, 8'd2,   8'd4,   SUB, 8'd254,  4'b1000, 2, 8'd2};
      tv[1]  = '{PS, 8'd99,  8'd99,  MUL, 8'd8,    4'b0000, 9, 8'd2};
      tv[2]  = '{LD, 8'd200, 8'd100, ADD, 8'd44,   4'b1000, 2, 8'd200};
      tv[3]  = '{LD, 8'd100, 8'd100, ADD, 8'd200,  4'b0100, 2, 8'd100};
      tv[4]  = '{LD, 8'd255, 8'd255, MUL, 8'd1,    4'b1000, 9, 8'd255};
      tv[5]  = '{LD, 8'h57,  8'h1A,  7'b0000011,
                 8'h00, 4'b0011, 2, 8'h57};
      tv[6]  = '{LD, 8'h57,  8'h1A,  XOR, 8'h4D,   4'b0000, 2, 8'h57};
      tv[7]  = '{LD, 8'hF0,  8'h3C,  AND, 8'h30,   4'b0000, 2, 8'hF0};
      tv[8]  = '{LD, 8'hF0,  8'h3C,  OR,  8'hFC,   4'b0000, 2, 8'hF0};
      tv[9]  = '{LD, 8'h0F,  8'hAA,  NOT, 8'hF0,   4'b0000, 2, 8'h0F};
      tv[10] = '{LD, 8'd5,   8'd5,   SUB, 8'd0,    4'b0010, 2, 8'd5};
      tv[11] = '{LD, 8'h80,  8'h01,  SUB, 8'h7F,   4'b0100, 2, 8'h80};
      tv[12] = '{LD, 8'h7F,  8'h01,  ADD, 8'h80,   4'b0100, 2, 8'h7F};
      tv[13] = '{LD, 8'd0,   8'd200, MUL, 8'd0,    4'b0010, 9, 8'd0};
      tv[14] = '{LD, 8'd16,  8'd16,  MUL, 8'd0,    4'b1010, 9, 8'd16};

      // reset overrides a pending load
      rst     = 1'b1;
      on      = 1'b1;
      in_sel  = LD;
      num1    = 8'hAA;
      num2    = 8'h55;
      out_sel = ADD;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 32'(curr_state), 32'd0);
      chk("rst_regs", {final1, final2, out}, 24'd0);
      chk("rst_flags", 32'(flags()), 32'd0);
      chk("rst_busy_done", {busy, done}, 2'b00);
      @(negedge clk);
      rst    = 1'b0;
      in_sel = 3'b000;

      // ADD 87/26 state trace
      @(negedge clk);
      in_sel  = LD;
      num1    = 8'd87;
      num2    = 8'd26;
      out_sel = ADD;
      #1;
      chk("trace_ns", 32'(next_state), 32'd1);
      @(posedge clk);
      #1;
      in_sel = 3'b000;
      chk("trace_e0", {busy, done, curr_state}, 4'b1001);
      @(posedge clk);
      #1;
      chk("trace_e1", {busy, done, curr_state}, 4'b1010);
      @(posedge clk);
      #1;
      chk("trace_e2", {busy, done, curr_state}, 4'b0111);
      chk("trace_out", 32'(out), 32'd113);
      chk("trace_flg", 32'(flags()), 32'd0);
      @(posedge clk);
      #1;
      chk("trace_e3", {busy, done, curr_state}, 4'b0000);

      for (int i = 0; i < 15; i++)
         run($sformatf("v%0d", i), tv[i]);

      // reset during MUL iteration 3
      @(negedge clk);
      in_sel  = LD;
      num1    = 8'd3;
      num2    = 8'd5;
      out_sel = MUL;
      @(posedge clk);
      #1;
      in_sel = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mrst_state", {busy, done, curr_state}, 4'b0000);
      chk("mrst_regs", {final1, final2, out}, 24'd0);
      chk("mrst_flags", 32'(flags()), 32'd0);
      watch_no_done("mrst_nodone", 12);
      v = '{LD, 8'd3, 8'd5, MUL, 8'd15, 4'b0000, 9, 8'd3};
      run("mrst_redo", v);

      // enable dropped mid-EXEC
      v = '{LD, 8'd87, 8'd26, ADD, 8'd113, 4'b0000, 2, 8'd87};
      run("pre_on", v);
      @(negedge clk);
      in_sel  = LD;
      num1    = 8'd9;
      num2    = 8'd7;
      out_sel = MUL;
      @(posedge clk);
      #1;
      in_sel = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      chk("off_exec", 32'(curr_state), 32'd2);
      on = 1'b0;
      @(posedge clk);
      #1;
      chk("off_state", {busy, done, curr_state}, 4'b0000);
      chk("off_ops", {final1, final2}, {8'd9, 8'd7});
      chk("off_out", 32'(out), 32'd113);
      on = 1'b1;
      watch_no_done("off_nodone", 12);
      v = '{LD, 8'd9, 8'd7, MUL, 8'd63, 4'b0000, 9, 8'd9};
      run("off_redo", v);

      // clear also drops err
      v = '{LD, 8'd3, 8'd4, 7'b0000000, 8'd0, 4'b0011, 2, 8'd3};
      run("pre_clr", v);
      @(negedge clk);
      in_sel = CL;
      @(posedge clk);
      #1;
      in_sel = 3'b000;
      chk("clr_regs", {final1, final2, out}, 24'd0);
      chk("clr_flags", 32'(flags()), 32'd0);
      chk("clr_state", 32'(curr_state), 32'd0);

      // load held through busy and DONE is ignored
      @(negedge clk);
      in_sel  = LD;
      num1    = 8'd10;
      num2    = 8'd20;
      out_sel = ADD;
      @(posedge clk);
      #1;
      num1 = 8'd1;
      num2 = 8'd1;
      repeat (2) @(posedge clk);
      #1;
      chk("bsy_done", {done, curr_state}, 3'b111);
      chk("bsy_ops", {final1, final2}, {8'd10, 8'd20});
      chk("bsy_out", 32'(out), 32'd30);
      @(posedge clk);
      #1;
      chk("bsy_idle", 32'(curr_state), 32'd0);
      @(posedge clk);
      #1;
      in_sel = 3'b000;
      chk("b2b_load", {final1, curr_state}, {8'd1, 2'b01});
      begin
         int lat;
         lat = 0;
         while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
         end
         chk("b2b_lat", lat, 2);
         chk("b2b_out", 32'(out), 32'd2);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/alu_fsm_core.md
# alu_fsm_core

Parametrised, multi-cycle successor to the team's 8-bit operand-register ALU. It latches two WIDTH-bit operands and a one-hot operation select under an `in_sel` command, then runs a 4-state controller (IDLE/LOAD/EXEC/DONE). Single-cycle ops complete in EXEC in one cycle; MUL is a WIDTH-cycle shift-add. Registered result, status flags and a one-cycle `done` pulse are presented to the surrounding datapath, with `curr_state` and `next_state` exported for the bench display.

## Interface
- WIDTH, 8: operand, result and register width; legal range ≥2.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- on  input  1  enable; 0 forces IDLE at the next edge.
- in_sel  input  3  one-hot command {persist, load, clear}: 100 persist, 010 load, 001 clear; any other value is a no-op.
- num1, num2  input  WIDTH  operand inputs.
- out_sel  input  7  one-hot op: b6 ADD, b5 SUB, b4 MUL, b3 AND, b2 OR, b1 XOR, b0 NOT(final1).
- final1, final2  output  WIDTH  latched operand registers.
- out  output  WIDTH  registered result.
- carry, ovf, zero, err  output  1  registered status flags.
- busy  output  1  high in LOAD and EXEC.
- done  output  1  one-cycle pulse in DONE.
- curr_state  output  2  registered state: IDLE 00, LOAD 01, EXEC 10, DONE 11.
- next_state  output  2  combinational next state.

## Operation
- Commands are sampled only when `curr_state` is IDLE and `on`=1. They are ignored in every other state.
- load: `final1`←`num1`, `final2`←`num2`, op register←`out_sel`; go to LOAD.
- persist: operands are held; op register←`out_sel`; go to LOAD. This re-executes on the held operands.
- clear: `final1`, `final2`, `out` and all flags are set to 0; stay in IDLE.
- LOAD always goes to EXEC.
- EXEC:
  - Non-MUL ops compute, register `out` and flags, and go to DONE.
  - MUL runs one shift-add iteration per cycle on a 2·WIDTH accumulator with an iteration counter. After WIDTH iterations it registers the low WIDTH bits into `out` and goes to DONE.
- DONE always goes to IDLE. `done`=1 only in DONE.
- Arithmetic is modulo 2^WIDTH.
  - ADD: `carry` = carry-out; `ovf` = signed overflow.
  - SUB (final1−final2): `carry` = borrow (final1<final2 unsigned); `ovf` = signed overflow.
  - MUL: `carry` = upper WIDTH product bits nonzero; `ovf`=0.
  - Logic ops: `carry`=`ovf`=0.
  - `zero` = (`out`==0) for every executed op.
- Invalid op register (zero bits or more than one bit set): EXEC takes one cycle, `out`=0, `err`=1, `carry`=`ovf`=0, `zero`=1. `err` is cleared at the next valid execution or clear.
- `out` and flags hold their value until the next EXEC completion, clear, or reset.

## Timing
- Reset: at a rising edge with `rst`=1, `curr_state`=IDLE and every register output = 0 (`final1`, `final2`, `out`, all flags, `busy`, `done`). `next_state` then evaluates from IDLE. `rst` overrides `on` and `in_sel`.
- Reset mid-operation (LOAD, EXEC including partial MUL, or DONE) aborts the operation with no `done` pulse. The MUL accumulator and counter are zeroed.
- Latency, counted from load/persist sampling edge E0:
  - Non-MUL: `out`, flags and `done` are valid after edge E0+2.
  - MUL: valid after edge E0+WIDTH+1.
  - IDLE is re-entered after one further edge.
- Back-to-back: a command present while DONE is active is ignored. The earliest next command is sampled at the first edge in IDLE.
- `on`=0 in any state: IDLE at the next edge. Registers are held, no `done` pulse, partial MUL is discarded, `busy`=0.
- `on`=1 with `rst`=1 at the same edge: reset wins.

## Test plan
- Reset, then load 87/26 with ADD (WIDTH=8) → `out`=113, `carry`=0, `ovf`=0, `zero`=0, `done` high after E0+2, states 01→10→11→00.
- Load 2/4 with SUB → `out`=254, `carry`=1, `ovf`=0; then persist with MUL → `out`=8, `carry`=0, `done` after E0+9, `busy` high for 8 EXEC cycles plus LOAD.
- Load 200/100 with ADD → `out`=44, `carry`=1. Load 100/100 with ADD → `out`=200, `ovf`=1. Load 255/255 with MUL → `out`=1, `carry`=1.
- Load 0x57/0x1A with `out_sel`=0000011 → `err`=1, `out`=0, `zero`=1. Next load with XOR → `err`=0, `out`=0x4D.
- Assert `rst` at MUL iteration 3 → next edge: all outputs 0, IDLE, no `done`. Drop `on` mid-EXEC → IDLE, `final1`/`final2` held.
- Issue clear in IDLE → `final1`=`final2`=`out`=0. Issue load while `busy` → ignored, operands unchanged.
